// File: rtl/riot_pkg.sv
// Shared constants and the bus-access decode for the MM6532 interval-timer controller.
package riot_pkg;

  localparam logic [1:0] C_PRESCALE_0001T = 2'b00;
  localparam logic [1:0] C_PRESCALE_0008T = 2'b01;
  localparam logic [1:0] C_PRESCALE_0064T = 2'b10;
  localparam logic [1:0] C_PRESCALE_1024T = 2'b11;

  localparam int A_TMR_SEL  = 4;
  localparam int A_IRQ_EN   = 3;
  localparam int A_REG_SEL  = 2;
  localparam int A_RD_FLAGS = 0;

  localparam int FLAG_TIMER = 7;
  localparam int FLAG_PA7   = 6;

  typedef enum logic [2:0] {
    ACC_NONE,
    ACC_WR_TIMER,
    ACC_WR_EDGE,
    ACC_RD_TIMER,
    ACC_RD_FLAGS,
    ACC_RD_UNMAPPED
  } access_e;

  // Unmapped reads are kept distinct so they can still drive DO to zero.
  function automatic access_e decode_access(input logic cs, input logic rw,
                                            input logic [4:0] a);
    access_e acc;
    acc = ACC_NONE;
    if (cs) begin
      if (!a[A_REG_SEL])
        acc = rw ? ACC_RD_UNMAPPED : ACC_NONE;
      else if (rw)
        acc = a[A_RD_FLAGS] ? ACC_RD_FLAGS : ACC_RD_TIMER;
      else
        acc = a[A_TMR_SEL] ? ACC_WR_TIMER : ACC_WR_EDGE;
    end
    return acc;
  endfunction

endpackage

// File: rtl/riot_edge_det.sv
// Multi-flop synchroniser followed by a polarity-selectable single-cycle edge pulse.
module riot_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic pos_sel,
  output logic pulse
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
    end
  end

  // Polarity only picks which transition counts, so flipping it on a steady input cannot fire.
  assign pulse = pos_sel ? (sync[STAGES-1] & ~prev) : (~sync[STAGES-1] & prev);

endmodule

// File: rtl/riot_timer_ctrl.sv
// CPU-side controller for the MM6532 interval timer: access decode, flags, IRQ enables and IRQ_N.
// The PA7 edge interrupt path is only built when RIOT_PA7_IRQ_EN is defined.
module riot_timer_ctrl
  import riot_pkg::*;
#(
  parameter int PA7_SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RES_N,
  input  logic       CS,
  input  logic       RW,
  input  logic [4:0] A,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  output logic       IRQ_N,
  input  logic       PA7,
  output logic       TMR_WE,
  output logic [1:0] TMR_PRESCALE,
  output logic [7:0] TMR_IN,
  input  logic [7:0] TMR_OUT,
  input  logic       TMR_INT
);

  access_e    acc;
  logic       timer_flag;
  logic       timer_flag_nxt;
  logic       timer_en;
  logic       pa7_flag;
  logic       pa7_en;
  logic [7:0] flags;

  assign acc = decode_access(CS, RW, A);

  // A reload discards any pending underflow; a plain read loses to a new underflow.
  always_comb begin
    timer_flag_nxt = timer_flag;
    if (acc == ACC_WR_TIMER)
      timer_flag_nxt = 1'b0;
    else if (TMR_INT)
      timer_flag_nxt = 1'b1;
    else if (acc == ACC_RD_TIMER)
      timer_flag_nxt = 1'b0;
  end

  always_comb begin
    flags             = '0;
    flags[FLAG_TIMER] = timer_flag;
    flags[FLAG_PA7]   = pa7_flag;
  end

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      DO           <= '0;
      IRQ_N        <= 1'b1;
      TMR_WE       <= 1'b0;
      TMR_PRESCALE <= C_PRESCALE_0001T;
      TMR_IN       <= '0;
      timer_flag   <= 1'b0;
      timer_en     <= 1'b0;
    end else begin
      TMR_WE     <= 1'b0;
      timer_flag <= timer_flag_nxt;
      IRQ_N      <= ~((timer_flag & timer_en) | (pa7_flag & pa7_en));
      case (acc)
        ACC_WR_TIMER: begin
          TMR_WE       <= 1'b1;
          TMR_IN       <= DI;
          TMR_PRESCALE <= A[1:0];
          timer_en     <= A[A_IRQ_EN];
        end
        ACC_RD_TIMER: begin
          DO       <= TMR_OUT;
          timer_en <= A[A_IRQ_EN];
        end
        ACC_RD_FLAGS:    DO <= flags;
        ACC_RD_UNMAPPED: DO <= '0;
        default: ;
      endcase
    end
  end

`ifdef RIOT_PA7_IRQ_EN
  logic edge_pos;
  logic pa7_edge;

  riot_edge_det #(
    .STAGES(PA7_SYNC_STAGES)
  ) u_pa7_edge (
    .clk    (CLK),
    .rst_n  (RES_N),
    .din    (PA7),
    .pos_sel(edge_pos),
    .pulse  (pa7_edge)
  );

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      pa7_flag <= 1'b0;
      pa7_en   <= 1'b0;
      edge_pos <= 1'b0;
    end else begin
      if (acc == ACC_WR_EDGE) begin
        pa7_en   <= A[1];
        edge_pos <= A[0];
      end
      if (pa7_edge)
        pa7_flag <= 1'b1;
      else if (acc == ACC_RD_FLAGS)
        pa7_flag <= 1'b0;
    end
  end
`else
  logic unused_pa7;
  assign unused_pa7 = PA7;
  assign pa7_flag   = 1'b0;
  assign pa7_en     = 1'b0;
`endif

endmodule

// File: tb/tb_riot_timer_ctrl.sv
// Directed bench for riot_timer_ctrl: a vector table for single-cycle accesses plus
// hand-written PA7 and asynchronous-reset sequences.
module tb_riot_timer_ctrl;

  localparam int SYNC_STAGES = 2;

  logic       CLK;
  logic       RES_N;
  logic       CS;
  logic       RW;
  logic [4:0] A;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       IRQ_N;
  logic       PA7;
  logic       TMR_WE;
  logic [1:0] TMR_PRESCALE;
  logic [7:0] TMR_IN;
  logic [7:0] TMR_OUT;
  logic       TMR_INT;

  int checks = 0;
  int errors = 0;

  riot_timer_ctrl #(
    .PA7_SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .CLK         (CLK),
    .RES_N       (RES_N),
    .CS          (CS),
    .RW          (RW),
    .A           (A),
    .DI          (DI),
    .DO          (DO),
    .IRQ_N       (IRQ_N),
    .PA7         (PA7),
    .TMR_WE      (TMR_WE),
    .TMR_PRESCALE(TMR_PRESCALE),
    .TMR_IN      (TMR_IN),
    .TMR_OUT     (TMR_OUT),
    .TMR_INT     (TMR_INT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic       cs;
    logic       rw;
    logic [4:0] a;
    logic [7:0] di;
    logic [7:0] tmr_out;
    logic       tmr_int;
    logic [7:0] exp_do;
    logic       exp_we;
    logic [7:0] exp_in;
    logic [1:0] exp_pre;
    logic       exp_irq_n;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic cs, input logic rw, input logic [4:0] a,
                              input logic [7:0] di, input logic [7:0] tmr_out,
                              input logic tmr_int, input logic [7:0] exp_do,
                              input logic exp_we, input logic [7:0] exp_in,
                              input logic [1:0] exp_pre, input logic exp_irq_n);
    vec_t v;
    v.cs = cs; v.rw = rw; v.a = a; v.di = di; v.tmr_out = tmr_out; v.tmr_int = tmr_int;
    v.exp_do = exp_do; v.exp_we = exp_we; v.exp_in = exp_in;
    v.exp_pre = exp_pre; v.exp_irq_n = exp_irq_n;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one access at a negedge; outputs are valid at the following negedge.
  task automatic apply_stimulus(input logic cs, input logic rw, input logic [4:0] a,
                                input logic [7:0] di, input logic [7:0] tmr_out,
                                input logic tmr_int);
    CS = cs; RW = rw; A = a; DI = di; TMR_OUT = tmr_out; TMR_INT = tmr_int;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 5'd0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic read_flags();
    apply_stimulus(1'b1, 1'b1, 5'b00101, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic write_edge(input logic [4:0] a);
    apply_stimulus(1'b1, 1'b0, a, 8'h00, 8'h00, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  lat;
    bit  seen;

    RES_N = 1'b0; CS = 1'b0; RW = 1'b0; A = '0; DI = '0; PA7 = 1'b0;
    TMR_OUT = '0; TMR_INT = 1'b0;

    //             cs   rw   a         di     tout   int   do     we   in     pre    irq_n
    vecs.push_back(mk(1, 0, 5'b11110, 8'h05, 8'h00, 0, 8'h00, 1, 8'h05, 2'b10, 1));
    vecs.push_back(mk(0, 0, 5'b00000, 8'h00, 8'h00, 0, 8'h00, 0, 8'h05, 2'b10, 1));
    vecs.push_back(mk(0, 0, 5'b00000, 8'h00, 8'h00, 1, 8'h00, 0, 8'h05, 2'b10, 1));
    vecs.push_back(mk(0, 0, 5'b00000, 8'h00, 8'h00, 0, 8'h00, 0, 8'h05, 2'b10, 0));
    vecs.push_back(mk(1, 1, 5'b00101, 8'h00, 8'h00, 0, 8'h80, 0, 8'h05, 2'b10, 0));
    vecs.push_back(mk(1, 1, 5'b01100, 8'h00, 8'h3C, 0, 8'h3C, 0, 8'h05, 2'b10, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 8'h00, 8'h00, 0, 8'h3C, 0, 8'h05, 2'b10, 1));
    vecs.push_back(mk(1, 1, 5'b00101, 8'h00, 8'h00, 0, 8'h00, 0, 8'h05, 2'b10, 1));
    vecs.push_back(mk(1, 1, 5'b01100, 8'h00, 8'h77, 1, 8'h77, 0, 8'h05, 2'b10, 1));
    vecs.push_back(mk(0, 0, 5'b00000, 8'h00, 8'h00, 0, 8'h77, 0, 8'h05, 2'b10, 0));
    vecs.push_back(mk(1, 1, 5'b00101, 8'h00, 8'h00, 0, 8'h80, 0, 8'h05, 2'b10, 0));
    vecs.push_back(mk(1, 0, 5'b11101, 8'hA5, 8'h00, 1, 8'h80, 1, 8'hA5, 2'b01, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 8'h00, 8'h00, 0, 8'h80, 0, 8'hA5, 2'b01, 1));
    vecs.push_back(mk(1, 1, 5'b00101, 8'h00, 8'h00, 0, 8'h00, 0, 8'hA5, 2'b01, 1));
    vecs.push_back(mk(1, 0, 5'b11100, 8'h11, 8'h00, 0, 8'h00, 1, 8'h11, 2'b00, 1));
    vecs.push_back(mk(1, 0, 5'b11111, 8'h22, 8'h00, 0, 8'h00, 1, 8'h22, 2'b11, 1));
    vecs.push_back(mk(1, 1, 5'b00100, 8'h00, 8'h5A, 0, 8'h5A, 0, 8'h22, 2'b11, 1));
    vecs.push_back(mk(1, 1, 5'b11010, 8'h00, 8'h99, 0, 8'h00, 0, 8'h22, 2'b11, 1));
    vecs.push_back(mk(1, 0, 5'b11011, 8'hFF, 8'h00, 0, 8'h00, 0, 8'h22, 2'b11, 1));
    vecs.push_back(mk(0, 0, 5'b00000, 8'h00, 8'h00, 1, 8'h00, 0, 8'h22, 2'b11, 1));
    vecs.push_back(mk(0, 0, 5'b00000, 8'h00, 8'h00, 0, 8'h00, 0, 8'h22, 2'b11, 1));
    vecs.push_back(mk(1, 1, 5'b00101, 8'h00, 8'h00, 0, 8'h80, 0, 8'h22, 2'b11, 1));
    vecs.push_back(mk(0, 1, 5'b01100, 8'h00, 8'hEE, 0, 8'h80, 0, 8'h22, 2'b11, 1));
    vecs.push_back(mk(1, 0, 5'b00100, 8'hFF, 8'h00, 0, 8'h80, 0, 8'h22, 2'b11, 1));

    repeat (2) @(negedge CLK);
    check_output("reset DO", DO, 8'h00);
    check_output("reset IRQ_N", 8'(IRQ_N), 8'h01);
    check_output("reset TMR_WE", 8'(TMR_WE), 8'h00);
    check_output("reset TMR_IN", TMR_IN, 8'h00);
    check_output("reset TMR_PRESCALE", 8'(TMR_PRESCALE), 8'h00);
    RES_N = 1'b1;
    @(negedge CLK);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].cs, vecs[i].rw, vecs[i].a, vecs[i].di, vecs[i].tmr_out,
                     vecs[i].tmr_int);
      check_output($sformatf("vec%0d DO", i), DO, vecs[i].exp_do);
      check_output($sformatf("vec%0d TMR_WE", i), 8'(TMR_WE), 8'(vecs[i].exp_we));
      check_output($sformatf("vec%0d TMR_IN", i), TMR_IN, vecs[i].exp_in);
      check_output($sformatf("vec%0d TMR_PRESCALE", i), 8'(TMR_PRESCALE), 8'(vecs[i].exp_pre));
      check_output($sformatf("vec%0d IRQ_N", i), 8'(IRQ_N), 8'(vecs[i].exp_irq_n));
    end

    // Clear the leftover timer flag (enable off) before looking at PA7.
    apply_stimulus(1'b1, 1'b1, 5'b00100, 8'h00, 8'h00, 1'b0);
    read_flags();
    check_output("flags clear before pa7", DO, 8'h00);

`ifdef RIOT_PA7_IRQ_EN
    write_edge(5'b00111);
    PA7  = 1'b1;
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      idle(1);
      if (IRQ_N == 1'b0) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check_output("pa7 rise irq seen", 8'(seen), 8'h01);
    check_output("pa7 rise irq latency", 8'(lat), 8'(SYNC_STAGES + 2));
    read_flags();
    check_output("pa7 flags read", DO, 8'h40);
    idle(1);
    check_output("pa7 irq after clear", 8'(IRQ_N), 8'h01);
    read_flags();
    check_output("pa7 flag cleared", DO, 8'h00);

    PA7 = 1'b0;
    idle(6);
    check_output("pa7 fall ignored irq", 8'(IRQ_N), 8'h01);
    read_flags();
    check_output("pa7 fall ignored flag", DO, 8'h00);

    write_edge(5'b00110);
    PA7 = 1'b1;
    idle(6);
    check_output("pa7 rise under neg irq", 8'(IRQ_N), 8'h01);
    write_edge(5'b00111);
    idle(6);
    check_output("pa7 sel neg to pos irq", 8'(IRQ_N), 8'h01);
    write_edge(5'b00110);
    idle(4);
    check_output("pa7 sel pos to neg irq", 8'(IRQ_N), 8'h01);
    read_flags();
    check_output("pa7 sel switch flag", DO, 8'h00);

    PA7 = 1'b0;
    idle(6);
    check_output("pa7 neg edge irq", 8'(IRQ_N), 8'h00);
    read_flags();
    check_output("pa7 neg edge flag", DO, 8'h40);
    idle(1);
    check_output("pa7 neg edge irq cleared", 8'(IRQ_N), 8'h01);
`else
    write_edge(5'b00111);
    PA7 = 1'b1;
    idle(6);
    check_output("pa7 disabled irq rise", 8'(IRQ_N), 8'h01);
    read_flags();
    check_output("pa7 disabled flag rise", DO, 8'h00);
    PA7 = 1'b0;
    idle(6);
    check_output("pa7 disabled irq fall", 8'(IRQ_N), 8'h01);
    read_flags();
    check_output("pa7 disabled flag fall", DO, 8'h00);
`endif

    // Build up IRQ_N=0, DO!=0 and a live TMR_WE, then reset asynchronously mid-write.
    apply_stimulus(1'b1, 1'b1, 5'b01100, 8'h00, 8'h00, 1'b0);
    idle(1);
    apply_stimulus(1'b0, 1'b0, 5'd0, 8'h00, 8'h00, 1'b1);
    idle(1);
    check_output("pre-reset IRQ_N", 8'(IRQ_N), 8'h00);
    read_flags();
    check_output("pre-reset DO", DO, 8'h80);
    apply_stimulus(1'b1, 1'b0, 5'b11110, 8'h99, 8'h00, 1'b0);
    check_output("pre-reset TMR_WE", 8'(TMR_WE), 8'h01);

    CS = 1'b1; RW = 1'b0; A = 5'b11110; DI = 8'h77;
    #1 RES_N = 1'b0;
    #1;
    check_output("async reset DO", DO, 8'h00);
    check_output("async reset IRQ_N", 8'(IRQ_N), 8'h01);
    check_output("async reset TMR_WE", 8'(TMR_WE), 8'h00);
    check_output("async reset TMR_IN", TMR_IN, 8'h00);
    check_output("async reset TMR_PRESCALE", 8'(TMR_PRESCALE), 8'h00);
    @(negedge CLK);
    CS = 1'b0;
    RES_N = 1'b1;
    idle(1);
    check_output("post-reset TMR_WE", 8'(TMR_WE), 8'h00);
    check_output("post-reset TMR_IN", TMR_IN, 8'h00);
    check_output("post-reset IRQ_N", 8'(IRQ_N), 8'h01);
    idle(1);
    check_output("post-reset TMR_WE late", 8'(TMR_WE), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riot_timer_ctrl.md
Name: riot_timer_ctrl

Overview:
CPU-side controller for the MM6532 interval timer. It decodes bus accesses into timer loads, prescale selection and readback, and latches the timer and PA7 edge interrupt flags. It owns the interrupt-enable bits and drives the open-drain-style IRQ_N. It sits between the mm6532 bus decode and the interval timer instance; RAM and I/O port registers are out of scope.

Parameters:
PA7_SYNC_STAGES, 2, number of flops synchronising PA7 before edge detection (range 2..4)

Ports:
CLK  in  1  system clock
RES_N  in  1  asynchronous active-low reset
CS  in  1  access strobe; one access per CLK edge while high
RW  in  1  1 = read, 0 = write
A  in  5  register address A[4:0]
DI  in  8  write data
DO  out  8  registered read data
IRQ_N  out  1  active-low interrupt request
PA7  in  1  asynchronous edge-interrupt input
TMR_WE  out  1  one-cycle timer load strobe
TMR_PRESCALE  out  2  prescale code to timer (00 1T, 01 8T, 10 64T, 11 1024T)
TMR_IN  out  8  timer load value
TMR_OUT  in  8  current timer count
TMR_INT  in  1  timer underflow pulse (one cycle)

Behaviour:
- Reset (asynchronous, RES_N=0): DO=0, IRQ_N=1, TMR_WE=0, TMR_PRESCALE=00, TMR_IN=0. Timer flag, PA7 flag, timer IRQ enable, PA7 IRQ enable and edge select (negative) all cleared. Synchroniser cleared to 0.
- Decode is evaluated only on edges where CS=1; accesses to unmapped codes are ignored, and such reads return DO=0.
- Write timer (RW=0, A[4]=1, A[2]=1): TMR_WE=1 for exactly the next cycle, TMR_IN=DI, TMR_PRESCALE=A[1:0]. Timer IRQ enable is set to A[3]. The timer flag is cleared.
- Write edge control (RW=0, A[4]=0, A[2]=1): PA7 IRQ enable is set to A[1] and edge select to A[0] (1 = positive, 0 = negative).
- Read timer (RW=1, A[2]=1, A[0]=0): DO=TMR_OUT sampled at the access edge and valid the following cycle. Timer IRQ enable is set to A[3]. The timer flag is cleared.
- Read flags (RW=1, A[2]=1, A[0]=1): DO={timer_flag, pa7_flag, 6'b0} as sampled before any update. The PA7 flag is cleared; the timer flag is unaffected.
- Read latency is one cycle. DO holds its value until the next read access.
- Timer flag: set when TMR_INT=1. Simultaneous set and read-timer clear: set wins. Simultaneous set and write-timer clear: clear wins, because the timer is reloaded.
- PA7 flag: set on a synchronised edge matching the edge select. Edge detection compares consecutive synchronised samples, so changing the edge select never creates a false edge. Simultaneous edge and read-flags clear: set wins.
- IRQ_N is registered: IRQ_N = !((timer_flag & timer_en) | (pa7_flag & pa7_en)), updated one cycle after the flag or enable changes.
- Back-to-back timer writes on consecutive cycles: the last write wins and TMR_WE stays high for each following cycle.
- Reset mid-access: all effects are abandoned and any pending TMR_WE is dropped.

Optional Feature:
RIOT_PA7_IRQ_EN
- Defined: PA7 synchroniser, edge detector, PA7 flag and PA7 enable are built as described above.
- Undefined: PA7 is ignored and the PA7 flag reads 0 (DO[6]=0). Edge-control writes are accepted but have no effect. IRQ_N depends only on the timer term.

Decomposition:
- Package riot_pkg holds:
  - prescale code constants shared with the timer: C_PRESCALE_0001T, C_PRESCALE_0008T, C_PRESCALE_0064T, C_PRESCALE_1024T;
  - address bit positions (A_TMR_SEL=4, A_REG_SEL=2, A_IRQ_EN=3);
  - flag bit positions (FLAG_TIMER=7, FLAG_PA7=6).
- One sub-module, riot_edge_det: parameterised synchroniser plus polarity-selectable single-cycle edge pulse.

Test Plan:
- Reset, then write timer with A=5'b11110, DI=8'h05 -> next cycle TMR_WE=1, TMR_IN=05, TMR_PRESCALE=10, timer IRQ enabled; IRQ_N stays 1.
- Pulse TMR_INT with timer IRQ enabled -> flag set; IRQ_N=0 one cycle later. Read flags -> DO=8'h80; IRQ_N remains 0. Read timer with A[3]=1 -> flag cleared; IRQ_N=1 one cycle later.
- TMR_INT in the same cycle as a read-timer access -> flag stays set. TMR_INT in the same cycle as a write-timer access -> flag cleared.
- With RIOT_PA7_IRQ_EN defined: write edge control A=5'b00111, drive PA7 0->1 -> PA7 flag set after PA7_SYNC_STAGES+1 cycles, IRQ_N=0. Read flags -> DO=8'h40, then PA7 flag cleared. A 1->0 transition with positive edge selected -> no flag.
- Hold PA7 high and switch edge select from negative to positive -> no flag set.
- Assert RES_N=0 asynchronously mid-write -> IRQ_N=1, TMR_WE=0, DO=0 immediately; no load pulse after release.
